// File: rtl/evo_scheduler.sv
// rtl/evo_scheduler.sv - Game-of-Life generation scheduler: programmable tick, run/pause/step/clear FSM
// Hands generations to the round engine via evo_start/round_done and owns the ping-pong bank select.
module evo_scheduler #(
  parameter int BASE_PERIOD = 10_000_000,
  parameter int SPEED_W     = 2,
  parameter int CNT_W       = 32,
  parameter int GEN_W       = 16
) (
  input  logic               clk_vga,
  input  logic               reset_btn,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               step,
  input  logic [SPEED_W-1:0] speed,
  input  logic               round_done,
  output logic               evo_start,
  output logic               bank_sel,
  output logic               busy,
  output logic [1:0]         state,
  output logic [GEN_W-1:0]   gen_count,
  output logic               overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_STEP  = 2'd3;

  // One extra bit so BASE_PERIOD itself need not fit in the counter.
  localparam logic [CNT_W:0] BASE_EXT = (CNT_W+1)'(BASE_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             discard;
  logic [CNT_W:0]   period_shr;
  logic [CNT_W-1:0] period_m1;
  logic             tick_due;
  logic             can_issue;
  logic             done_ok;

  assign period_shr = BASE_EXT >> speed;
  assign period_m1  = (period_shr == '0) ? '0 : CNT_W'(period_shr - 1'b1);
  assign tick_due   = (cnt >= period_m1);
  // A round_done landing with a tick frees the engine for that same tick.
  assign can_issue  = (!busy || round_done) && !evo_start;
  assign done_ok    = round_done && busy;

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gen_count <= '0;
      evo_start <= 1'b0;
      busy      <= 1'b0;
      bank_sel  <= 1'b0;
      overrun   <= 1'b0;
      discard   <= 1'b0;
    end else begin
      evo_start <= 1'b0;

      if (done_ok) begin
        busy <= 1'b0;
        if (discard) begin
          discard <= 1'b0;
        end else begin
          bank_sel  <= ~bank_sel;
          gen_count <= gen_count + 1'b1;
        end
      end

      if (clear) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        gen_count <= '0;
        bank_sel  <= 1'b0;
        overrun   <= 1'b0;
        // An in-flight generation belongs to the old world; swallow its done.
        discard   <= busy && !round_done;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pause) begin
              state <= ST_IDLE;
            end else if (start) begin
              if (!discard) begin
                state <= ST_RUN;
                cnt   <= '0;
              end
            end else if (step && !busy) begin
              state     <= ST_STEP;
              evo_start <= 1'b1;
              busy      <= 1'b1;
            end
          end

          ST_RUN: begin
            if (pause) begin
              state <= ST_PAUSE;
            end else if (tick_due) begin
              cnt <= '0;
              if (can_issue) begin
                evo_start <= 1'b1;
                busy      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_PAUSE: begin
            if (pause) begin
              state <= ST_PAUSE;
            end else if (start) begin
              state <= ST_RUN;
            end else if (step && !busy) begin
              state     <= ST_STEP;
              evo_start <= 1'b1;
              busy      <= 1'b1;
            end
          end

          default: begin
            if (done_ok) begin
              state <= ST_PAUSE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_evo_scheduler.sv
// tb/tb_evo_scheduler.sv - directed self-checking bench for evo_scheduler
// Table of per-cycle vectors at P=2, then hand-written multi-cycle sequences at P=8.
module tb_evo_scheduler;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_CLR  = 4'b1000;
  localparam logic [3:0] C_PAU  = 4'b0100;
  localparam logic [3:0] C_STA  = 4'b0010;
  localparam logic [3:0] C_STP  = 4'b0001;

  logic        clk_vga;
  logic        reset_btn;
  logic        start;
  logic        pause;
  logic        clear;
  logic        step;
  logic [1:0]  speed;
  logic        round_done;
  logic        evo_start;
  logic        bank_sel;
  logic        busy;
  logic [1:0]  state;
  logic [15:0] gen_count;
  logic        overrun;

  int total;
  int bad;

  evo_scheduler #(
    .BASE_PERIOD(8),
    .SPEED_W(2),
    .CNT_W(8),
    .GEN_W(16)
  ) dut (
    .clk_vga(clk_vga),
    .reset_btn(reset_btn),
    .start(start),
    .pause(pause),
    .clear(clear),
    .step(step),
    .speed(speed),
    .round_done(round_done),
    .evo_start(evo_start),
    .bank_sel(bank_sel),
    .busy(busy),
    .state(state),
    .gen_count(gen_count),
    .overrun(overrun)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  typedef struct {
    logic [3:0]  cmd;
    logic        rd;
    logic [1:0]  st;
    logic        es;
    logic        bz;
    logic        bk;
    logic [15:0] gc;
    logic        ov;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic r);
    {clear, pause, start, step} = c;
    round_done = r;
    @(posedge clk_vga);
    #1;
    {clear, pause, start, step} = C_NONE;
    round_done = 1'b0;
  endtask

  task automatic do_reset();
    {clear, pause, start, step} = C_NONE;
    round_done = 1'b0;
    reset_btn = 1'b1;
    @(posedge clk_vga);
    #1;
    reset_btn = 1'b0;
  endtask

  initial begin
    int n;
    int last;
    int first;
    int es_k[3];

    total = 0;
    bad = 0;
    speed = 2'd2;

    //         cmd            rd  st  es bz bk gc ov
    tbl[0]  = '{C_STA,         0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{C_NONE,        0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{C_NONE,        0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{C_NONE,        0, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{C_NONE,        1, 1, 1, 1, 1, 1, 0};
    tbl[5]  = '{C_NONE,        0, 1, 0, 1, 1, 1, 0};
    tbl[6]  = '{C_NONE,        0, 1, 0, 1, 1, 1, 1};
    tbl[7]  = '{C_NONE,        1, 1, 0, 0, 0, 2, 1};
    tbl[8]  = '{C_PAU,         0, 2, 0, 0, 0, 2, 1};
    tbl[9]  = '{C_NONE,        0, 2, 0, 0, 0, 2, 1};
    tbl[10] = '{C_STP,         0, 3, 1, 1, 0, 2, 1};
    tbl[11] = '{C_STP,         0, 3, 0, 1, 0, 2, 1};
    tbl[12] = '{C_STA,         0, 3, 0, 1, 0, 2, 1};
    tbl[13] = '{C_NONE,        1, 2, 0, 0, 1, 3, 1};
    tbl[14] = '{C_CLR,         0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{C_PAU,         0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{C_STP,         0, 3, 1, 1, 0, 0, 0};
    tbl[17] = '{C_CLR,         0, 0, 0, 1, 0, 0, 0};
    tbl[18] = '{C_STA,         0, 0, 0, 1, 0, 0, 0};
    tbl[19] = '{C_NONE,        1, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{C_CLR|C_PAU|C_STA, 0, 0, 0, 0, 0, 0, 0};
    tbl[21] = '{C_STA|C_STP,   0, 1, 0, 0, 0, 0, 0};
    tbl[22] = '{C_PAU|C_STA,   0, 2, 0, 0, 0, 0, 0};
    tbl[23] = '{C_STA|C_STP,   0, 1, 0, 0, 0, 0, 0};
    tbl[24] = '{C_CLR,         0, 0, 0, 0, 0, 0, 0};

    do_reset();
    chk("rst_state", 32'(state), 0);
    chk("rst_evo_start", 32'(evo_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bank", 32'(bank_sel), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_overrun", 32'(overrun), 0);

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].cmd, tbl[i].rd);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_evo_start", i), 32'(evo_start), 32'(tbl[i].es));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("vec%0d_bank", i), 32'(bank_sel), 32'(tbl[i].bk));
      chk($sformatf("vec%0d_gen", i), 32'(gen_count), 32'(tbl[i].gc));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].ov));
    end

    // basic run at P=8, engine answers 3 cycles after each evo_start
    do_reset();
    speed = 2'd0;
    cyc(C_STA, 0);
    n = 0;
    last = -100;
    es_k = '{-1, -1, -1};
    for (int k = 1; k <= 30; k++) begin
      cyc(C_NONE, k == last + 3);
      if (evo_start) begin
        if (n < 3) es_k[n] = k;
        n++;
        last = k;
      end
      if (k == 11) chk("run_bank_after_1", 32'(bank_sel), 1);
      if (k == 19) chk("run_bank_after_2", 32'(bank_sel), 0);
    end
    chk("run_pulses", n, 3);
    chk("run_es0", es_k[0], 8);
    chk("run_es1", es_k[1], 16);
    chk("run_es2", es_k[2], 24);
    chk("run_gen30", 32'(gen_count), 3);
    chk("run_bank30", 32'(bank_sel), 1);

    // speed change mid-count: 2->0 at cnt=1, 0->2 at cnt=5, done coincident with a tick
    do_reset();
    speed = 2'd2;
    cyc(C_STA, 0);
    n = 0;
    last = -100;
    es_k = '{-1, -1, -1};
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) speed = 2'd0;
      if (k == 14) speed = 2'd2;
      cyc(C_NONE, k == last + 2);
      if (evo_start) begin
        if (n < 3) es_k[n] = k;
        n++;
        last = k;
      end
    end
    chk("spd_pulses", n, 3);
    chk("spd_es0", es_k[0], 8);
    chk("spd_es1", es_k[1], 14);
    chk("spd_es2", es_k[2], 16);

    // pause at cnt=3, hold, resume
    do_reset();
    speed = 2'd0;
    cyc(C_STA, 0);
    repeat (3) cyc(C_NONE, 0);
    cyc(C_PAU, 0);
    n = 0;
    repeat (20) begin
      cyc(C_NONE, 0);
      if (evo_start) n++;
    end
    chk("pause_no_pulse", n, 0);
    chk("pause_state", 32'(state), 2);
    cyc(C_STA, 0);
    chk("resume_state", 32'(state), 1);
    first = -1;
    for (int j = 1; j <= 6; j++) begin
      cyc(C_NONE, 0);
      if (evo_start && first < 0) first = j;
    end
    chk("resume_latency", first, 5);

    // pause during an in-flight generation, step blocked while busy, then step
    do_reset();
    speed = 2'd0;
    cyc(C_STA, 0);
    repeat (8) cyc(C_NONE, 0);
    chk("inflight_es", 32'(evo_start), 1);
    cyc(C_PAU, 0);
    chk("inflight_pause_state", 32'(state), 2);
    chk("inflight_pause_busy", 32'(busy), 1);
    cyc(C_STP, 0);
    chk("step_busy_state", 32'(state), 2);
    chk("step_busy_es", 32'(evo_start), 0);
    cyc(C_NONE, 1);
    chk("inflight_done_busy", 32'(busy), 0);
    chk("inflight_done_gen", 32'(gen_count), 1);
    chk("inflight_done_bank", 32'(bank_sel), 1);
    cyc(C_STP, 0);
    chk("step_state", 32'(state), 3);
    chk("step_es", 32'(evo_start), 1);
    repeat (3) cyc(C_NONE, 0);
    chk("step_wait_state", 32'(state), 3);
    chk("step_wait_busy", 32'(busy), 1);
    cyc(C_NONE, 1);
    chk("step_done_state", 32'(state), 2);
    chk("step_done_gen", 32'(gen_count), 2);
    chk("step_done_bank", 32'(bank_sel), 0);

    // overrun: engine holds off 20 cycles
    do_reset();
    speed = 2'd0;
    cyc(C_STA, 0);
    n = 0;
    first = -1;
    for (int k = 1; k <= 27; k++) begin
      cyc(C_NONE, 0);
      if (evo_start) begin
        n++;
        if (first < 0) first = k;
      end
      if (k == 15) chk("ovr_before", 32'(overrun), 0);
      if (k == 16) chk("ovr_set", 32'(overrun), 1);
    end
    chk("ovr_pulses", n, 1);
    chk("ovr_first", first, 8);
    chk("ovr_sticky", 32'(overrun), 1);
    cyc(C_NONE, 1);
    chk("ovr_done_busy", 32'(busy), 0);
    chk("ovr_after_done", 32'(overrun), 1);
    chk("ovr_done_gen", 32'(gen_count), 1);
    cyc(C_CLR, 0);
    chk("ovr_cleared", 32'(overrun), 0);

    // asynchronous reset mid-generation
    do_reset();
    speed = 2'd0;
    cyc(C_STA, 0);
    repeat (9) cyc(C_NONE, 0);
    chk("arst_pre_busy", 32'(busy), 1);
    #2;
    reset_btn = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_state", 32'(state), 0);
    #1;
    reset_btn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
